hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline control block for the five-stage core: the producer of the `enable`/`flush` controls that every pipeline latch (ifid, idex, exmem, memwb) consumes.
- Compares register tags and memory/branch status from the latch outputs and decides per cycle which latches advance, hold or bubble, and whether the PC advances.
- Tracks data-memory waits and halt draining in a small state machine.
- Keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports (clock and reset first):
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID (`regbits_t`).
- ifid_use_rs, ifid_use_rt  in  1 each  instruction in ID reads that operand.
- idex_wsel  in  5  destination register of the instruction in EX.
- idex_WEN, idex_dREN, idex_halt  in  1 each  EX instruction writes a register / loads / is halt.
- idex_redirect  in  1  branch taken or jump resolved in EX.
- exmem_wsel  in  5  destination register of the instruction in MEM.
- exmem_WEN, exmem_dREN, exmem_dWEN  in  1 each  MEM instruction write, load and store flags.
- memwb_wsel  in  5  destination register of the instruction in WB.
- memwb_WEN, memwb_halt  in  1 each  WB write and halt flags.
- ihit, dhit  in  1 each  cache handshakes.
- pc_en  out  1  PC loads its next value.
- ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_enable, exmem_flush, memwb_enable, memwb_flush  out  1 each  latch controls. Flush takes priority over enable inside each latch.
- halted  out  1  core stopped.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
States:
- RUN.
- DWAIT: a memory op is in MEM and dhit is not yet seen.
- HALT: sticky until RST.

Transitions:
- RUN→DWAIT when (exmem_dREN|exmem_dWEN)&!dhit.
- DWAIT→RUN on dhit.
- Any→HALT on memwb_halt (checked first).

Per-cycle controls in RUN/DWAIT, first matching rule wins; every control not named defaults to enable=1, flush=0, pc_en=1:
1. Memory wait, (exmem_dREN|exmem_dWEN)&!dhit: pc_en, ifid/idex/exmem enable =0; memwb_flush=1.
2. Redirect, idex_redirect: ifid_flush=1, idex_flush=1, pc_en=1.
3. Data hazard, a match with rd≠0 against a used ifid_rs/rt:
   - With FORWARDING_EN: only idex_dREN&idex_WEN&idex_wsel match.
   - Without FORWARDING_EN: any WEN match in idex, exmem or memwb.
   - Action: pc_en=0, ifid_enable=0, idex_flush=1.
4. Halt draining, idex_halt: ifid_flush=1, pc_en=0.
5. Fetch miss, !ihit: pc_en=0, ifid_flush=1.

In HALT: all enables 0, all flushes 0, pc_en=0, halted=1.

Counters:
- stall_cnt +1 on each cycle matching rule 1, 3 or 5.
- flush_cnt +1 on each cycle matching rule 2.
- Both saturate at all-ones.

## Timing
- Controls are combinational from the current state and inputs (Mealy) and are consumed by the latches on the same edge. State, halted and counters are registered.
- Reset values: state RUN; halted 0; counters 0. Reset also forces every latch flush to 1 and pc_en to 0 during the reset cycle.
- A load-use stall lasts exactly 1 cycle with FORWARDING_EN.
- Without FORWARDING_EN, a dependency stalls until the producer leaves WB: up to 3 cycles.
- Redirect costs 2 bubbles.
- dhit and redirect in the same cycle: rule 1 is not taken, redirect applies.
- RST asserted mid-DWAIT returns to RUN on the next edge regardless of dhit.
- halted rises the cycle after memwb_halt and never falls without RST.

## Configuration
- FORWARDING_EN defined: a forwarding unit exists; stall only on load-use against EX.
- FORWARDING_EN undefined: full RAW interlock against EX, MEM and WB destinations.

## Structure
- Put the `hz_state_t` enum (RUN, DWAIT, HALT) in cpu_types_pkg next to `regbits_t` and `pcselect_t`.
- Sub-module `hazard_detect`: combinational tag compare producing `data_hazard`, compiled per FORWARDING_EN.

## Test plan
- lw $2 in EX, add reading $2 in ID, FORWARDING_EN → one cycle: pc_en=0, ifid_enable=0, idex_flush=1; stall_cnt=1.
- Same with FORWARDING_EN undefined and add $3 producer in MEM → stall each cycle until memwb_wsel=3 drains (2 cycles), then pc_en=1.
- sw in MEM, dhit low 4 cycles → state DWAIT, memwb_flush=1 for 4 cycles, stall_cnt=4, RUN on dhit.
- idex_redirect=1 with ihit=0 → ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1.
- halt in EX then WB → pc_en=0 from EX; halted=1 the cycle after memwb_halt; all enables 0 thereafter.
- RST during DWAIT → next cycle state RUN, counters 0, halted 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register tags, PC select codes and hazard-unit states.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pcselect_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hz_state_t;

  // True when a consumed source operand names a real (non-$0) destination.
  function automatic logic reg_match(input logic use_src, input regbits_t src, input regbits_t dst);
    return use_src && (src == dst) && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Register-tag compare between the ID instruction and older in-flight producers.
// FORWARDING_EN selects load-use-only detection; otherwise a full RAW interlock.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_use_rs,
  input  logic     ifid_use_rt,
  input  regbits_t idex_wsel,
  input  logic     idex_WEN,
  input  logic     idex_dREN,
  input  regbits_t exmem_wsel,
  input  logic     exmem_WEN,
  input  regbits_t memwb_wsel,
  input  logic     memwb_WEN,
  output logic     data_hazard
);

  logic hit_ex_s;
  logic hit_mem_s;
  logic hit_wb_s;

  always_comb begin
    hit_ex_s  = reg_match(ifid_use_rs, ifid_rs, idex_wsel)  | reg_match(ifid_use_rt, ifid_rt, idex_wsel);
    hit_mem_s = reg_match(ifid_use_rs, ifid_rs, exmem_wsel) | reg_match(ifid_use_rt, ifid_rt, exmem_wsel);
    hit_wb_s  = reg_match(ifid_use_rs, ifid_rs, memwb_wsel) | reg_match(ifid_use_rt, ifid_rt, memwb_wsel);
  end

`ifdef FORWARDING_EN
  // Results from MEM and WB are forwarded; only a load still in EX is too late.
  logic unused_s;
  assign unused_s    = ^{hit_mem_s, hit_wb_s, exmem_WEN, memwb_WEN};
  assign data_hazard = hit_ex_s & idex_WEN & idex_dREN;
`else
  logic unused_s;
  assign unused_s    = idex_dREN;
  assign data_hazard = (hit_ex_s & idex_WEN) | (hit_mem_s & exmem_WEN) | (hit_wb_s & memwb_WEN);
`endif

endmodule

// File: rtl/hazard_unit.sv
// Pipeline enable/flush/PC control with data-memory wait and halt tracking.
// Optional macro FORWARDING_EN reduces data-hazard stalls to load-use only.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             ifid_use_rs,
  input  logic             ifid_use_rt,
  input  regbits_t         idex_wsel,
  input  logic             idex_WEN,
  input  logic             idex_dREN,
  input  logic             idex_halt,
  input  logic             idex_redirect,
  input  regbits_t         exmem_wsel,
  input  logic             exmem_WEN,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  regbits_t         memwb_wsel,
  input  logic             memwb_WEN,
  input  logic             memwb_halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             pc_en,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             exmem_flush,
  output logic             memwb_enable,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_t        state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             data_hazard_s;
  logic             mem_wait_s;
  logic             stall_inc_s;
  logic             flush_inc_s;

  hazard_detect u_detect (
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .ifid_use_rs (ifid_use_rs),
    .ifid_use_rt (ifid_use_rt),
    .idex_wsel   (idex_wsel),
    .idex_WEN    (idex_WEN),
    .idex_dREN   (idex_dREN),
    .exmem_wsel  (exmem_wsel),
    .exmem_WEN   (exmem_WEN),
    .memwb_wsel  (memwb_wsel),
    .memwb_WEN   (memwb_WEN),
    .data_hazard (data_hazard_s)
  );

  assign mem_wait_s = (exmem_dREN | exmem_dWEN) & ~dhit;

  // Prioritised per-cycle latch controls; earlier rules mask later ones.
  always_comb begin
    pc_en        = 1'b1;
    ifid_enable  = 1'b1;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b1;
    idex_flush   = 1'b0;
    exmem_enable = 1'b1;
    exmem_flush  = 1'b0;
    memwb_enable = 1'b1;
    memwb_flush  = 1'b0;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    if (RST) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == HALT) begin
      pc_en        = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwb_enable = 1'b0;
    end else if (mem_wait_s) begin
      pc_en        = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwb_flush  = 1'b1;
      stall_inc_s  = 1'b1;
    end else if (idex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      flush_inc_s = 1'b1;
    end else if (data_hazard_s) begin
      pc_en       = 1'b0;
      ifid_enable = 1'b0;
      idex_flush  = 1'b1;
      stall_inc_s = 1'b1;
    end else if (idex_halt) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end else if (!ihit) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      stall_inc_s = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // State transitions; a halt reaching WB overrides everything but reset.
  always_comb begin
    state_d = state_q;
    if (RST) begin
      state_d = RUN;
    end else if (memwb_halt) begin
      state_d = HALT;
    end else begin
      case (state_q)
        RUN:     state_d = mem_wait_s ? DWAIT : RUN;
        DWAIT:   state_d = dhit ? RUN : DWAIT;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
    halted_d = (state_d == HALT);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (RST) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (flush_inc_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed cycles push expected controls,
// a negedge monitor pops and compares. A 2-bit-counter twin checks saturation.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  localparam logic [8:0] NORM   = 9'b1_10_10_10_10;
  localparam logic [8:0] RST_C  = 9'b0_11_11_11_11;
  localparam logic [8:0] MEMW   = 9'b0_00_00_00_11;
  localparam logic [8:0] REDIR  = 9'b1_11_11_10_10;
  localparam logic [8:0] DHAZ   = 9'b0_00_11_10_10;
  localparam logic [8:0] HDRAIN = 9'b0_11_10_10_10;
  localparam logic [8:0] FMISS  = 9'b0_11_10_10_10;
  localparam logic [8:0] HALTC  = 9'b0_00_00_00_00;

  localparam int K_NONE = 0, K_STALL = 1, K_FLUSH = 2, K_RST = 3, K_HALT = 4;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic        halted;
    hz_state_t   state;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [1:0]  sstall;
    logic [1:0]  sflush;
  } rec_t;

  logic CLK = 1'b0;
  logic RST;
  regbits_t ifid_rs, ifid_rt, idex_wsel, exmem_wsel, memwb_wsel;
  logic ifid_use_rs, ifid_use_rt, idex_WEN, idex_dREN, idex_halt, idex_redirect;
  logic exmem_WEN, exmem_dREN, exmem_dWEN, memwb_WEN, memwb_halt, ihit, dhit;

  logic pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic exmem_enable, exmem_flush, memwb_enable, memwb_flush, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic s_pc_en, s_ifid_enable, s_ifid_flush, s_idex_enable, s_idex_flush;
  logic s_exmem_enable, s_exmem_flush, s_memwb_enable, s_memwb_flush, s_halted;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  rec_t q[$];
  rec_t act_r, exp_r;
  int n_pass = 0;
  int n_total = 0;
  int mon_idx = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  logic m_halted = 1'b0;

  always #5 CLK = ~CLK;

  hazard_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_wsel(idex_wsel), .idex_WEN(idex_WEN), .idex_dREN(idex_dREN),
    .idex_halt(idex_halt), .idex_redirect(idex_redirect),
    .exmem_wsel(exmem_wsel), .exmem_WEN(exmem_WEN), .exmem_dREN(exmem_dREN),
    .exmem_dWEN(exmem_dWEN), .memwb_wsel(memwb_wsel), .memwb_WEN(memwb_WEN),
    .memwb_halt(memwb_halt), .ihit(ihit), .dhit(dhit),
    .pc_en(pc_en), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .memwb_enable(memwb_enable), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut_s (
    .CLK(CLK), .RST(RST), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_wsel(idex_wsel), .idex_WEN(idex_WEN), .idex_dREN(idex_dREN),
    .idex_halt(idex_halt), .idex_redirect(idex_redirect),
    .exmem_wsel(exmem_wsel), .exmem_WEN(exmem_WEN), .exmem_dREN(exmem_dREN),
    .exmem_dWEN(exmem_dWEN), .memwb_wsel(memwb_wsel), .memwb_WEN(memwb_WEN),
    .memwb_halt(memwb_halt), .ihit(ihit), .dhit(dhit),
    .pc_en(s_pc_en), .ifid_enable(s_ifid_enable), .ifid_flush(s_ifid_flush),
    .idex_enable(s_idex_enable), .idex_flush(s_idex_flush),
    .exmem_enable(s_exmem_enable), .exmem_flush(s_exmem_flush),
    .memwb_enable(s_memwb_enable), .memwb_flush(s_memwb_flush),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic logic [1:0] sat2(input logic [31:0] v);
    return (v > 32'd3) ? 2'd3 : v[1:0];
  endfunction

  task automatic idle();
    RST = 1'b0;
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_use_rs = 1'b0; ifid_use_rt = 1'b0;
    idex_wsel = 5'd0; idex_WEN = 1'b0; idex_dREN = 1'b0; idex_halt = 1'b0; idex_redirect = 1'b0;
    exmem_wsel = 5'd0; exmem_WEN = 1'b0; exmem_dREN = 1'b0; exmem_dWEN = 1'b0;
    memwb_wsel = 5'd0; memwb_WEN = 1'b0; memwb_halt = 1'b0;
    ihit = 1'b1; dhit = 1'b1;
  endtask

  task automatic nc();
    @(posedge CLK);
    #1;
    idle();
  endtask

  // Push this cycle's expectation, then advance the counter/halt model.
  task automatic cyc(input logic [8:0] c, input hz_state_t st, input int kind);
    rec_t r;
    r.ctrl = c; r.halted = m_halted; r.state = st;
    r.stall = m_stall; r.flush = m_flush;
    r.sstall = sat2(m_stall); r.sflush = sat2(m_flush);
    q.push_back(r);
    case (kind)
      K_STALL: m_stall = m_stall + 32'd1;
      K_FLUSH: m_flush = m_flush + 32'd1;
      K_RST:   begin m_stall = 32'd0; m_flush = 32'd0; m_halted = 1'b0; end
      K_HALT:  m_halted = 1'b1;
      default: ;
    endcase
  endtask

  always @(negedge CLK) begin
    if (q.size() != 0) begin
      exp_r = q.pop_front();
      act_r.ctrl = {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
                    exmem_enable, exmem_flush, memwb_enable, memwb_flush};
      act_r.halted = halted;
      act_r.state = dut.state_q;
      act_r.stall = stall_cnt;
      act_r.flush = flush_cnt;
      act_r.sstall = s_stall_cnt;
      act_r.sflush = s_flush_cnt;
      n_total++;
      if (act_r === exp_r) n_pass++;
      else $display("FAIL vec%0d actual=%h required=%h", mon_idx, act_r, exp_r);
      mon_idx++;
    end
  end

  initial begin
    idle();
    RST = 1'b1;
    nc(); RST = 1'b1; cyc(RST_C, RUN, K_RST);
    nc(); cyc(NORM, RUN, K_NONE);
    // load $2 in EX, consumer of $2 waits in ID while the load moves on
    nc(); idex_wsel = 5'd2; idex_WEN = 1'b1; idex_dREN = 1'b1; ifid_rs = 5'd2; ifid_use_rs = 1'b1;
    cyc(DHAZ, RUN, K_STALL);
    nc(); exmem_wsel = 5'd2; exmem_WEN = 1'b1; exmem_dREN = 1'b1; ifid_rs = 5'd2; ifid_use_rs = 1'b1;
`ifdef FORWARDING_EN
    cyc(NORM, RUN, K_NONE);
`else
    cyc(DHAZ, RUN, K_STALL);
`endif
    nc(); memwb_wsel = 5'd2; memwb_WEN = 1'b1; ifid_rs = 5'd2; ifid_use_rs = 1'b1;
`ifdef FORWARDING_EN
    cyc(NORM, RUN, K_NONE);
`else
    cyc(DHAZ, RUN, K_STALL);
`endif
    nc(); ifid_rs = 5'd2; ifid_use_rs = 1'b1; cyc(NORM, RUN, K_NONE);
    // ALU producer of $3 in MEM then WB
    nc(); exmem_wsel = 5'd3; exmem_WEN = 1'b1; ifid_rt = 5'd3; ifid_use_rt = 1'b1;
`ifdef FORWARDING_EN
    cyc(NORM, RUN, K_NONE);
`else
    cyc(DHAZ, RUN, K_STALL);
`endif
    nc(); memwb_wsel = 5'd3; memwb_WEN = 1'b1; ifid_rt = 5'd3; ifid_use_rt = 1'b1;
`ifdef FORWARDING_EN
    cyc(NORM, RUN, K_NONE);
`else
    cyc(DHAZ, RUN, K_STALL);
`endif
    nc(); ifid_rt = 5'd3; ifid_use_rt = 1'b1; cyc(NORM, RUN, K_NONE);
    // $0 destination and unused operand never stall
    nc(); idex_WEN = 1'b1; idex_dREN = 1'b1; ifid_use_rs = 1'b1; cyc(NORM, RUN, K_NONE);
    nc(); idex_wsel = 5'd4; idex_WEN = 1'b1; idex_dREN = 1'b1; ifid_rt = 5'd4;
    ifid_rs = 5'd1; ifid_use_rs = 1'b1; cyc(NORM, RUN, K_NONE);
    nc(); idex_redirect = 1'b1; ihit = 1'b0; cyc(REDIR, RUN, K_FLUSH);
    nc(); idex_redirect = 1'b1; idex_wsel = 5'd5; idex_WEN = 1'b1; idex_dREN = 1'b1;
    ifid_rs = 5'd5; ifid_use_rs = 1'b1; exmem_dREN = 1'b1; cyc(REDIR, RUN, K_FLUSH);
    nc(); ihit = 1'b0; cyc(FMISS, RUN, K_STALL);
    // store in MEM waiting four cycles for dhit
    for (int i = 0; i < 4; i++) begin
      nc(); exmem_dWEN = 1'b1; dhit = 1'b0; cyc(MEMW, (i == 0) ? RUN : DWAIT, K_STALL);
    end
    nc(); exmem_dWEN = 1'b1; cyc(NORM, DWAIT, K_NONE);
    nc(); cyc(NORM, RUN, K_NONE);
    // memory wait beats redirect, then reset mid-wait
    nc(); exmem_dREN = 1'b1; dhit = 1'b0; idex_redirect = 1'b1; cyc(MEMW, RUN, K_STALL);
    nc(); RST = 1'b1; exmem_dREN = 1'b1; dhit = 1'b0; cyc(RST_C, DWAIT, K_RST);
    nc(); cyc(NORM, RUN, K_NONE);
    for (int i = 0; i < 4; i++) begin
      nc(); idex_redirect = 1'b1; cyc(REDIR, RUN, K_FLUSH);
    end
    // halt drains from EX to WB, then sticks until reset
    nc(); idex_halt = 1'b1; cyc(HDRAIN, RUN, K_NONE);
    nc(); idex_halt = 1'b1; ihit = 1'b0; cyc(HDRAIN, RUN, K_NONE);
    nc(); memwb_halt = 1'b1; cyc(NORM, RUN, K_HALT);
    nc(); ihit = 1'b0; idex_redirect = 1'b1; cyc(HALTC, HALT, K_NONE);
    nc(); exmem_dWEN = 1'b1; dhit = 1'b0; cyc(HALTC, HALT, K_NONE);
    nc(); RST = 1'b1; cyc(RST_C, HALT, K_RST);
    nc(); cyc(NORM, RUN, K_NONE);
    nc();
    @(negedge CLK);
    #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0 pending", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
